// File: rtl/track_recorder.sv
`default_nettype none
// ============================================================================
// Module   : track_recorder
// Purpose  : Record/playback engine between the codec's Avalon-ST channels
//            and the SDRAM controller's Avalon-MM slave (s1).
//            Record mode packs each stereo ADC frame as {R,L} into one 32-bit
//            SDRAM word at consecutive addresses. Play mode reads the words
//            back one at a time and presents them to the DAC sinks.
// Ports    : i_clk/i_rst             clock, synchronous active-high reset
//            i_record/i_play/i_stop  command pulses (stop > record > play)
//            from_adc_*              ADC Avalon-ST sinks (L/R)
//            to_dac_*                DAC Avalon-ST sources (L/R)
//            new_sdram_controller_0_s1_*  SDRAM Avalon-MM master side
//            o_state                 FSM state code
//            o_length                recorded frame count
// Revision : 1.0 - initial release
// ============================================================================
module track_recorder #(
  parameter int ADDR_W    = 25,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4194304
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_record,
  input  logic              i_play,
  input  logic              i_stop,
  output logic              from_adc_left_channel_ready,
  input  logic [15:0]       from_adc_left_channel_data,
  input  logic              from_adc_left_channel_valid,
  output logic              from_adc_right_channel_ready,
  input  logic [15:0]       from_adc_right_channel_data,
  input  logic              from_adc_right_channel_valid,
  output logic [15:0]       to_dac_left_channel_data,
  output logic              to_dac_left_channel_valid,
  input  logic              to_dac_left_channel_ready,
  output logic [15:0]       to_dac_right_channel_data,
  output logic              to_dac_right_channel_valid,
  input  logic              to_dac_right_channel_ready,
  output logic [ADDR_W-1:0] new_sdram_controller_0_s1_address,
  output logic [3:0]        new_sdram_controller_0_s1_byteenable_n,
  output logic              new_sdram_controller_0_s1_chipselect,
  output logic [31:0]       new_sdram_controller_0_s1_writedata,
  output logic              new_sdram_controller_0_s1_read_n,
  output logic              new_sdram_controller_0_s1_write_n,
  input  logic [31:0]       new_sdram_controller_0_s1_readdata,
  input  logic              new_sdram_controller_0_s1_readdatavalid,
  input  logic              new_sdram_controller_0_s1_waitrequest,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_length
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REC_CAP   = 3'd1;
  localparam logic [2:0] S_REC_WR    = 3'd2;
  localparam logic [2:0] S_PLAY_RD   = 3'd3;
  localparam logic [2:0] S_PLAY_WAIT = 3'd4;
  localparam logic [2:0] S_PLAY_OUT  = 3'd5;

  localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_MAX  = ADDR_W'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic [15:0]       smp_l_q, smp_l_d;
  logic [15:0]       smp_r_q, smp_r_d;
  logic              have_l_q, have_l_d;
  logic              have_r_q, have_r_d;
  logic              stop_lat_q, stop_lat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              dac_l_vld_q, dac_l_vld_d;
  logic              dac_r_vld_q, dac_r_vld_d;

  logic              adc_l_acc, adc_r_acc;
  logic              dac_l_done, dac_r_done;
  logic [ADDR_W-1:0] wptr_inc, rptr_inc;

  // ADC is always drained outside recording so the codec never stalls;
  // during capture each channel takes exactly one sample per frame.
  always_comb begin
    from_adc_left_channel_ready  = (state_q != S_REC_WR);
    from_adc_right_channel_ready = (state_q != S_REC_WR);
    if (state_q == S_REC_CAP) begin
      from_adc_left_channel_ready  = !have_l_q;
      from_adc_right_channel_ready = !have_r_q;
    end
  end

  assign adc_l_acc = (state_q == S_REC_CAP) && from_adc_left_channel_valid
                     && from_adc_left_channel_ready;
  assign adc_r_acc = (state_q == S_REC_CAP) && from_adc_right_channel_valid
                     && from_adc_right_channel_ready;

  // A channel counts as done once its valid is gone or is being accepted now.
  assign dac_l_done = !dac_l_vld_q || to_dac_left_channel_ready;
  assign dac_r_done = !dac_r_vld_q || to_dac_right_channel_ready;

  assign wptr_inc = wptr_q + C_ONE;
  assign rptr_inc = rptr_q + C_ONE;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    length_d    = length_q;
    smp_l_d     = smp_l_q;
    smp_r_d     = smp_r_q;
    have_l_d    = have_l_q;
    have_r_d    = have_r_q;
    stop_lat_d  = stop_lat_q;
    rdata_d     = rdata_q;
    dac_l_vld_d = dac_l_vld_q;
    dac_r_vld_d = dac_r_vld_q;

    case (state_q)
      S_IDLE: begin
        stop_lat_d = 1'b0;
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_record) begin
          wptr_d   = '0;
          length_d = '0;
          have_l_d = 1'b0;
          have_r_d = 1'b0;
          state_d  = S_REC_CAP;
        end else if (i_play && (length_q != '0)) begin
          rptr_d  = '0;
          state_d = S_PLAY_RD;
        end
      end

      S_REC_CAP: begin
        if (i_stop) begin
          // Partial frame is dropped; only fully written frames count.
          length_d = wptr_q;
          have_l_d = 1'b0;
          have_r_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          if (adc_l_acc) begin
            smp_l_d  = from_adc_left_channel_data;
            have_l_d = 1'b1;
          end
          if (adc_r_acc) begin
            smp_r_d  = from_adc_right_channel_data;
            have_r_d = 1'b1;
          end
          if ((have_l_q || adc_l_acc) && (have_r_q || adc_r_acc)) begin
            state_d = S_REC_WR;
          end
        end
      end

      S_REC_WR: begin
        // The in-flight write must complete, so stop is only remembered here.
        if (i_stop) stop_lat_d = 1'b1;
        if (!new_sdram_controller_0_s1_waitrequest) begin
          wptr_d     = wptr_inc;
          have_l_d   = 1'b0;
          have_r_d   = 1'b0;
          stop_lat_d = 1'b0;
          if (wptr_inc == C_MAX) begin
            length_d = C_MAX;
            state_d  = S_IDLE;
          end else if (stop_lat_q || i_stop) begin
            length_d = wptr_inc;
            state_d  = S_IDLE;
          end else begin
            state_d = S_REC_CAP;
          end
        end
      end

      S_PLAY_RD: begin
        if (i_stop) stop_lat_d = 1'b1;
        if (!new_sdram_controller_0_s1_waitrequest) state_d = S_PLAY_WAIT;
      end

      S_PLAY_WAIT: begin
        // Wait for the single outstanding read even when stopping, so no
        // stale readdatavalid can leak into a later transaction.
        if (i_stop) stop_lat_d = 1'b1;
        if (new_sdram_controller_0_s1_readdatavalid) begin
          stop_lat_d = 1'b0;
          if (stop_lat_q || i_stop) begin
            state_d = S_IDLE;
          end else begin
            rdata_d     = new_sdram_controller_0_s1_readdata;
            dac_l_vld_d = 1'b1;
            dac_r_vld_d = 1'b1;
            state_d     = S_PLAY_OUT;
          end
        end
      end

      S_PLAY_OUT: begin
        if (i_stop) begin
          dac_l_vld_d = 1'b0;
          dac_r_vld_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          if (dac_l_vld_q && to_dac_left_channel_ready)  dac_l_vld_d = 1'b0;
          if (dac_r_vld_q && to_dac_right_channel_ready) dac_r_vld_d = 1'b0;
          if (dac_l_done && dac_r_done) begin
            rptr_d  = rptr_inc;
            state_d = (rptr_inc == length_q) ? S_IDLE : S_PLAY_RD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      length_q    <= '0;
      smp_l_q     <= '0;
      smp_r_q     <= '0;
      have_l_q    <= 1'b0;
      have_r_q    <= 1'b0;
      stop_lat_q  <= 1'b0;
      rdata_q     <= '0;
      dac_l_vld_q <= 1'b0;
      dac_r_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      length_q    <= length_d;
      smp_l_q     <= smp_l_d;
      smp_r_q     <= smp_r_d;
      have_l_q    <= have_l_d;
      have_r_q    <= have_r_d;
      stop_lat_q  <= stop_lat_d;
      rdata_q     <= rdata_d;
      dac_l_vld_q <= dac_l_vld_d;
      dac_r_vld_q <= dac_r_vld_d;
    end
  end

  assign new_sdram_controller_0_s1_write_n      = (state_q != S_REC_WR);
  assign new_sdram_controller_0_s1_read_n       = (state_q != S_PLAY_RD);
  assign new_sdram_controller_0_s1_chipselect   = (state_q == S_REC_WR) ||
                                                  (state_q == S_PLAY_RD);
  assign new_sdram_controller_0_s1_address      = C_BASE +
                                                  ((state_q == S_PLAY_RD) ? rptr_q : wptr_q);
  assign new_sdram_controller_0_s1_writedata    = {smp_r_q, smp_l_q};
  assign new_sdram_controller_0_s1_byteenable_n = 4'b0000;

  assign to_dac_left_channel_data   = rdata_q[15:0];
  assign to_dac_right_channel_data  = rdata_q[31:16];
  assign to_dac_left_channel_valid  = dac_l_vld_q;
  assign to_dac_right_channel_valid = dac_r_vld_q;

  assign o_state  = state_q;
  assign o_length = length_q;

endmodule
`default_nettype wire

// File: tb/tb_track_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_track_recorder
// Purpose  : Scoreboard bench for track_recorder. Stimulus pushes expected
//            SDRAM writes, read addresses and DAC samples into queues; a
//            negedge monitor pops and compares on every accepted transfer.
//            A small SDRAM model answers reads 3 cycles after acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_track_recorder;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_record = 1'b0, i_play = 1'b0, i_stop = 1'b0;
  logic          adc_l_ready, adc_r_ready;
  logic [15:0]   adc_l_data = '0, adc_r_data = '0;
  logic          adc_l_valid = 1'b0, adc_r_valid = 1'b0;
  logic [15:0]   dac_l_data, dac_r_data;
  logic          dac_l_valid, dac_r_valid;
  logic          dac_l_ready = 1'b0, dac_r_ready = 1'b0;
  logic [AW-1:0] address;
  logic [3:0]    be_n;
  logic          cs;
  logic [31:0]   wdata;
  logic          rd_n, wr_n;
  logic [31:0]   rdata = '0;
  logic          rdv = 1'b0;
  logic          waitreq = 1'b0;
  logic [2:0]    o_state;
  logic [AW-1:0] o_length;

  always #5 clk = ~clk;

  track_recorder #(.ADDR_W(AW), .BASE_ADDR(0), .MAX_WORDS(4)) dut (
    .i_clk                                  (clk),
    .i_rst                                  (rst),
    .i_record                               (i_record),
    .i_play                                 (i_play),
    .i_stop                                 (i_stop),
    .from_adc_left_channel_ready            (adc_l_ready),
    .from_adc_left_channel_data             (adc_l_data),
    .from_adc_left_channel_valid            (adc_l_valid),
    .from_adc_right_channel_ready           (adc_r_ready),
    .from_adc_right_channel_data            (adc_r_data),
    .from_adc_right_channel_valid           (adc_r_valid),
    .to_dac_left_channel_data               (dac_l_data),
    .to_dac_left_channel_valid              (dac_l_valid),
    .to_dac_left_channel_ready              (dac_l_ready),
    .to_dac_right_channel_data              (dac_r_data),
    .to_dac_right_channel_valid             (dac_r_valid),
    .to_dac_right_channel_ready             (dac_r_ready),
    .new_sdram_controller_0_s1_address      (address),
    .new_sdram_controller_0_s1_byteenable_n (be_n),
    .new_sdram_controller_0_s1_chipselect   (cs),
    .new_sdram_controller_0_s1_writedata    (wdata),
    .new_sdram_controller_0_s1_read_n       (rd_n),
    .new_sdram_controller_0_s1_write_n      (wr_n),
    .new_sdram_controller_0_s1_readdata     (rdata),
    .new_sdram_controller_0_s1_readdatavalid(rdv),
    .new_sdram_controller_0_s1_waitrequest  (waitreq),
    .o_state                                (o_state),
    .o_length                               (o_length)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [56:0] exp_wr[$];   // {addr, data}
  logic [24:0] exp_rd[$];
  logic [15:0] exp_l[$];
  logic [15:0] exp_r[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got a transfer expected none", name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          wr_acc_n = 1'b0, rd_acc_n = 1'b0;
  logic [AW-1:0] addr_n = '0;
  logic [31:0]   wdata_n = '0;

  always @(negedge clk) begin
    logic [56:0] e;
    wr_acc_n = !rst && !wr_n && !waitreq;
    rd_acc_n = !rst && !rd_n && !waitreq;
    addr_n   = address;
    wdata_n  = wdata;
    if (!rst) begin
      if (!wr_n || !rd_n) chk("chipselect_active", {63'd0, cs}, 64'd1);
      if (!wr_n && !rd_n) unexpected("concurrent_rd_wr");
      if (wr_acc_n) begin
        if (exp_wr.size() == 0) unexpected("write");
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", {39'd0, address}, {39'd0, e[56:32]});
          chk("wr_data", {32'd0, wdata}, {32'd0, e[31:0]});
          chk("wr_be_n", {60'd0, be_n}, 64'd0);
        end
      end
      if (rd_acc_n) begin
        if (exp_rd.size() == 0) unexpected("read");
        else chk("rd_addr", {39'd0, address}, {39'd0, exp_rd.pop_front()});
      end
      if (dac_l_valid && dac_l_ready) begin
        if (exp_l.size() == 0) unexpected("dac_left");
        else chk("dac_left_data", {48'd0, dac_l_data}, {48'd0, exp_l.pop_front()});
      end
      if (dac_r_valid && dac_r_ready) begin
        if (exp_r.size() == 0) unexpected("dac_right");
        else chk("dac_right_data", {48'd0, dac_r_data}, {48'd0, exp_r.pop_front()});
      end
    end
  end

  // ---------------- SDRAM model ----------------
  logic [31:0] mem [16];
  int          lat_cnt = 0;
  logic [3:0]  raddr = '0;

  always @(posedge clk) begin
    #1;
    rdv = 1'b0;
    if (rst) begin
      lat_cnt = 0;
    end else if (rd_acc_n) begin
      lat_cnt = 2;
      raddr   = addr_n[3:0];
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        rdv   = 1'b1;
        rdata = mem[raddr];
      end
    end
    if (wr_acc_n) mem[addr_n[3:0]] = wdata_n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cmd(input logic rec, input logic ply, input logic stp);
    i_record = rec; i_play = ply; i_stop = stp;
    @(posedge clk); #1;
    i_record = 1'b0; i_play = 1'b0; i_stop = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    logic al, ar, dl, dr;
    int budget;
    adc_l_data = l; adc_r_data = r;
    adc_l_valid = 1'b1; adc_r_valid = 1'b1;
    dl = 1'b0; dr = 1'b0; budget = 50;
    while (!(dl && dr) && budget > 0) begin
      @(negedge clk);
      al = adc_l_valid && adc_l_ready;
      ar = adc_r_valid && adc_r_ready;
      @(posedge clk); #1;
      if (al) begin dl = 1'b1; adc_l_valid = 1'b0; end
      if (ar) begin dr = 1'b1; adc_r_valid = 1'b0; end
      budget--;
    end
    adc_l_valid = 1'b0; adc_r_valid = 1'b0;
    chk("adc_frame_accepted", {62'd0, dl, dr}, 64'd3);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int budget;
    budget = 100;
    @(negedge clk);
    while (o_state != s && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk(name, {61'd0, o_state}, {61'd0, s});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int budget;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {61'd0, o_state}, 64'd0);
    chk("rst_write_n", {63'd0, wr_n}, 64'd1);
    chk("rst_read_n", {63'd0, rd_n}, 64'd1);
    chk("rst_cs", {63'd0, cs}, 64'd0);
    chk("rst_length", {39'd0, o_length}, 64'd0);
    chk("rst_dac_valids", {62'd0, dac_l_valid, dac_r_valid}, 64'd0);
    chk("rst_adc_ready", {62'd0, adc_l_ready, adc_r_ready}, 64'd3);
    @(posedge clk); #1;

    // Record two frames then stop
    exp_wr.push_back({25'd0, 32'h2222_1111});
    exp_wr.push_back({25'd1, 32'h4444_3333});
    cmd(1'b1, 1'b0, 1'b0);
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    wait_state(3'd1, "rec_back_to_cap");
    @(posedge clk); #1;
    cmd(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rec_stop_state", {61'd0, o_state}, 64'd0);
    chk("rec_stop_length", {39'd0, o_length}, 64'd2);
    @(posedge clk); #1;

    // Playback with right DAC ready delayed 4 cycles
    exp_rd.push_back(25'd0); exp_rd.push_back(25'd1);
    exp_l.push_back(16'h1111); exp_l.push_back(16'h3333);
    exp_r.push_back(16'h2222); exp_r.push_back(16'h4444);
    dac_l_ready = 1'b1; dac_r_ready = 1'b0;
    cmd(1'b0, 1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      budget = 50;
      @(negedge clk);
      while (!dac_r_valid && budget > 0) begin @(negedge clk); budget--; end
      chk("play_right_valid", {63'd0, dac_r_valid}, 64'd1);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("play_hold_out", {61'd0, o_state}, 64'd5);
        chk("play_right_stable", {48'd0, dac_r_data}, (f == 0) ? 64'h2222 : 64'h4444);
      end
      @(posedge clk); #1 dac_r_ready = 1'b1;
      @(posedge clk); #1 dac_r_ready = 1'b0;
    end
    wait_state(3'd0, "play_done_idle");
    chk("play_length_kept", {39'd0, o_length}, 64'd2);
    @(posedge clk); #1;
    dac_r_ready = 1'b1;

    // waitrequest stall in REC_WR, stop latched during the stall
    waitreq = 1'b1;
    exp_wr.push_back({25'd0, 32'hBBBB_AAAA});
    cmd(1'b1, 1'b0, 1'b0);
    send_frame(16'hAAAA, 16'hBBBB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_write_n", {63'd0, wr_n}, 64'd0);
      chk("stall_addr", {39'd0, address}, 64'd0);
      chk("stall_data", {32'd0, wdata}, 64'hBBBB_AAAA);
      chk("stall_adc_ready", {62'd0, adc_l_ready, adc_r_ready}, 64'd0);
      @(posedge clk); #1;
      i_stop = (i == 2);
    end
    i_stop = 1'b0;
    waitreq = 1'b0;
    wait_state(3'd0, "stall_stop_idle");
    chk("stall_stop_length", {39'd0, o_length}, 64'd1);
    @(posedge clk); #1;

    // Capacity limit: four frames, automatic return to IDLE
    cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back({25'(i), 16'h0200 + 16'(i), 16'h0100 + 16'(i)});
      send_frame(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    end
    wait_state(3'd0, "max_auto_idle");
    chk("max_length", {39'd0, o_length}, 64'd4);
    chk("max_adc_ready", {62'd0, adc_l_ready, adc_r_ready}, 64'd3);
    @(posedge clk); #1;

    // Stop during PLAY_WAIT: read completes, no DAC output
    exp_rd.push_back(25'd0);
    cmd(1'b0, 1'b1, 1'b0);
    wait_state(3'd4, "pw_enter_wait");
    @(posedge clk); #1;
    cmd(1'b0, 1'b0, 1'b1);
    budget = 20;
    @(negedge clk);
    while (!rdv && budget > 0) begin @(negedge clk); budget--; end
    chk("pw_rdv_seen", {63'd0, rdv}, 64'd1);
    chk("pw_state_at_rdv", {61'd0, o_state}, 64'd4);
    @(negedge clk);
    chk("pw_idle_after_rdv", {61'd0, o_state}, 64'd0);
    chk("pw_no_dac_valid", {62'd0, dac_l_valid, dac_r_valid}, 64'd0);
    @(posedge clk); #1;

    // All three commands at once in IDLE: stop wins
    cmd(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("allcmd_state", {61'd0, o_state}, 64'd0);
    chk("allcmd_length", {39'd0, o_length}, 64'd4);
    @(posedge clk); #1;

    // Reset mid-write with waitrequest held
    waitreq = 1'b1;
    cmd(1'b1, 1'b0, 1'b0);
    send_frame(16'h5555, 16'h6666);
    @(negedge clk);
    chk("rstwr_in_write", {63'd0, wr_n}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstwr_write_n", {63'd0, wr_n}, 64'd1);
    chk("rstwr_cs", {63'd0, cs}, 64'd0);
    chk("rstwr_length", {39'd0, o_length}, 64'd0);
    chk("rstwr_state", {61'd0, o_state}, 64'd0);
    waitreq = 1'b0;
    repeat (3) @(posedge clk);

    chk("left_wr_queue", 64'(exp_wr.size()), 64'd0);
    chk("left_rd_queue", 64'(exp_rd.size()), 64'd0);
    chk("left_dac_l_queue", 64'(exp_l.size()), 64'd0);
    chk("left_dac_r_queue", 64'(exp_r.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/track_recorder.md
Name: track_recorder

Overview:
- Record/playback engine between the audio codec's Avalon-ST channels and the SDRAM controller's Avalon-MM slave (s1).
- Record mode: captures stereo ADC frames and packs each frame {R,L} into one 32-bit SDRAM word at consecutive addresses.
- Play mode: reads the recorded words back and streams them to the DAC sinks.
- Instantiated inside AcappellaCore as its SDRAM-facing track stage.

Parameters:
- ADDR_W, 25, SDRAM word-address width (matches s1_address).
- BASE_ADDR, 0, first word address of the track region.
- MAX_WORDS, 4194304, track capacity in frames; recording stops automatically at this count.

Ports:
- i_clk  in  1  system clock (50 MHz)
- i_rst  in  1  synchronous active-high reset
- i_record  in  1  start-record pulse
- i_play  in  1  start-play pulse
- i_stop  in  1  stop pulse
- from_adc_left_channel_ready  out  1  ADC left ready
- from_adc_left_channel_data  in  16  ADC left sample
- from_adc_left_channel_valid  in  1  ADC left valid
- from_adc_right_channel_ready/data/valid  out/in/in  1/16/1  same, right channel
- to_dac_left_channel_data  out  16  DAC left sample
- to_dac_left_channel_valid  out  1  DAC left valid
- to_dac_left_channel_ready  in  1  DAC left ready
- to_dac_right_channel_data/valid/ready  out/out/in  16/1/1  same, right channel
- new_sdram_controller_0_s1_address  out  ADDR_W  word address
- new_sdram_controller_0_s1_byteenable_n  out  4  always 4'b0000
- new_sdram_controller_0_s1_chipselect  out  1  high while read_n or write_n is low
- new_sdram_controller_0_s1_writedata  out  32  {R,L}
- new_sdram_controller_0_s1_read_n  out  1  active-low read
- new_sdram_controller_0_s1_write_n  out  1  active-low write
- new_sdram_controller_0_s1_readdata  in  32  read data
- new_sdram_controller_0_s1_readdatavalid  in  1  read data valid
- new_sdram_controller_0_s1_waitrequest  in  1  slave stall
- o_state  out  3  FSM state code
- o_length  out  ADDR_W  recorded frame count

Behaviour:
- Clocking and reset: one clock (i_clk); i_rst is synchronous, active-high.
- State after reset: IDLE.
  - read_n=1, write_n=1, chipselect=0.
  - DAC valids=0; wptr=rptr=0; o_length=0.
  - Reset mid-transaction abandons the transaction with no completion wait.
- FSM states (o_state code): IDLE=0, REC_CAP=1, REC_WR=2, PLAY_RD=3, PLAY_WAIT=4, PLAY_OUT=5.
- Command priority, same cycle: stop > record > play.
  - Record/play are acted on only in IDLE.
  - play is ignored when o_length==0.
- ADC ready (combinational):
  - Per channel, high in IDLE and all PLAY states; samples accepted there are discarded.
  - In REC_CAP, high only for a channel not yet captured in the current frame.
  - Low in REC_WR.
- IDLE + record: wptr=0, o_length=0, capture flags cleared -> REC_CAP.
- REC_CAP:
  - Latch a sample on valid&&ready per channel.
  - When both flags are set (same or different cycles) -> REC_WR next cycle.
  - stop -> IDLE; o_length=wptr; a partial frame is dropped.
- REC_WR:
  - Drive write_n=0, chipselect=1, address=BASE_ADDR+wptr, writedata={R,L}; all held stable while waitrequest=1.
  - On a cycle with waitrequest=0 the write is accepted: wptr+=1, flags cleared.
    - If wptr+1==MAX_WORDS -> IDLE, o_length=MAX_WORDS.
    - Else if a stop was latched during REC_WR -> IDLE, o_length=wptr+1.
    - Else -> REC_CAP.
- IDLE + play (o_length>0): rptr=0 -> PLAY_RD.
- PLAY_RD:
  - Drive read_n=0, chipselect=1, address=BASE_ADDR+rptr; held while waitrequest=1.
  - Accept -> PLAY_WAIT.
  - A stop here is latched, not acted on immediately.
- PLAY_WAIT:
  - Deassert read.
  - On readdatavalid: register readdata; exactly one read is outstanding.
    - If stop latched -> IDLE, data discarded.
    - Else -> PLAY_OUT with both DAC valids=1; left data=[15:0], right=[31:16].
- PLAY_OUT:
  - Each channel valid clears on its own valid&&ready cycle; data is stable while valid.
  - When both are accepted: rptr+=1. If rptr+1==o_length -> IDLE, else -> PLAY_RD.
  - stop -> IDLE next cycle, both valids=0.
- Writes and reads are never issued concurrently.
- Pointers do not wrap; addresses never exceed BASE_ADDR+MAX_WORDS-1.

Test Plan:
- Reset, then record; ADC supplies L=0x1111/R=0x2222 and L=0x3333/R=0x4444 with waitrequest=0; then stop -> writes at addr 0 data 0x22221111 and addr 1 data 0x44443333; o_length=2; IDLE.
- waitrequest held 1 for 5 cycles during REC_WR -> address, writedata and write_n held constant for all 5 cycles; ADC readies low; exactly one accepted write.
- Play after the first test; SDRAM model returns readdatavalid 3 cycles after accept; DAC right ready delayed 4 cycles -> left data 0x1111 and right data 0x2222 presented, then 0x3333/0x4444; rptr advances only after both are accepted; IDLE after 2 frames.
- MAX_WORDS=4, continuous ADC frames -> exactly 4 writes (addr 0..3); auto-IDLE; o_length=4; ADC readies high afterwards.
- stop asserted during PLAY_WAIT -> no DAC valid asserted; IDLE on the readdatavalid cycle; record+play+stop asserted together in IDLE -> stays IDLE.
- i_rst asserted in REC_WR with waitrequest=1 -> next cycle write_n=1, chipselect=0, o_length=0, o_state=0.
